// File: rtl/pattern_player.sv
// Pattern playback engine: host-loaded lane RAMs are streamed out on p_out at a programmable
// rate, one-shot or looping, with a CSR slave for control and a completion interrupt.
module pattern_player #(
    parameter int outputBits  = 32,
    parameter int words_log_2 = 0,
    parameter int timeBits    = 10,
    parameter int divBits     = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            buffer_write,
    input  logic [timeBits+words_log_2-1:0] buffer_address,
    input  logic [31:0]                     buffer_writedata,
    input  logic                            csr_write,
    input  logic                            csr_read,
    input  logic [1:0]                      csr_address,
    input  logic [31:0]                     csr_writedata,
    output logic [31:0]                     csr_readdata,
    output logic                            irq,
    output logic [outputBits-1:0]           p_out,
    output logic                            p_strobe,
    output logic                            p_active
);

    localparam int LANES = 1 << words_log_2;
    localparam int DEPTH = 1 << timeBits;

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [timeBits-1:0]     play_addr_reg, play_addr_next;
    logic [timeBits-1:0]     length_reg;
    logic [divBits-1:0]      div_reg;
    logic [divBits-1:0]      div_cnt_reg, div_cnt_next;
    logic                    loop_reg;
    logic                    done_reg, done_next;
    logic                    irq_reg, irq_next;
    logic                    tick_d_reg;
    logic                    p_strobe_reg;
    logic [outputBits-1:0]   p_out_reg;
    logic [31:0]             csr_readdata_reg;
    logic [outputBits-1:0]   sample_q;
    logic [timeBits-1:0]     wr_index;
    logic                    ctrl_wr, abort, tick, last;
    logic                    unused_ok;

    assign wr_index = buffer_address[timeBits+words_log_2-1:words_log_2];
    assign ctrl_wr  = csr_write && (csr_address == 2'd0);
    assign abort    = ctrl_wr && !csr_writedata[0];
    // An abort landing on a tick cycle swallows that tick entirely.
    assign tick     = (state_reg == PLAY) && (div_cnt_reg == '0) && !abort;
    assign last     = (play_addr_reg >= length_reg);
    assign unused_ok = &{1'b0, csr_writedata};

    // One RAM per 32-bit host lane; the top lane only keeps bits that reach p_out.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam int LW = (outputBits - gi * 32 >= 32) ? 32 : (outputBits - gi * 32);
            logic [LW-1:0] mem [DEPTH];
            logic [LW-1:0] q_reg;
            logic          lane_we;

            if (words_log_2 == 0) begin : g_single
                assign lane_we = buffer_write;
            end else begin : g_multi
                assign lane_we = buffer_write &&
                                 (buffer_address[words_log_2-1:0] == words_log_2'(gi));
            end

            always_ff @(posedge clk) begin
                if (lane_we)
                    mem[wr_index] <= buffer_writedata[LW-1:0];
                if (tick)
                    q_reg <= mem[play_addr_reg];
            end

            assign sample_q[gi*32 +: LW] = q_reg;
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        play_addr_next = play_addr_reg;
        div_cnt_next   = div_cnt_reg;
        done_next      = done_reg;
        irq_next       = irq_reg;
        if (ctrl_wr && csr_writedata[3])
            irq_next = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (ctrl_wr && csr_writedata[0]) begin
                    state_next     = PLAY;
                    play_addr_next = '0;
                    div_cnt_next   = '0;
                    done_next      = 1'b0;
                end
            end
            PLAY: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    div_cnt_next = (div_cnt_reg >= div_reg) ? '0 : div_cnt_reg + 1'b1;
                    if (tick) begin
                        if (!last) begin
                            play_addr_next = play_addr_reg + 1'b1;
                        end else if (loop_reg) begin
                            play_addr_next = '0;
                        end else begin
                            // Completion sets irq after the clear above, so set wins.
                            state_next = DONE;
                            done_next  = 1'b1;
                            irq_next   = 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            play_addr_reg    <= '0;
            div_cnt_reg      <= '0;
            done_reg         <= 1'b0;
            irq_reg          <= 1'b0;
            loop_reg         <= 1'b0;
            length_reg       <= '1;
            div_reg          <= '0;
            csr_readdata_reg <= '0;
            tick_d_reg       <= 1'b0;
            p_strobe_reg     <= 1'b0;
            p_out_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            play_addr_reg <= play_addr_next;
            div_cnt_reg   <= div_cnt_next;
            done_reg      <= done_next;
            irq_reg       <= irq_next;
            if (csr_write) begin
                case (csr_address)
                    2'd0:    loop_reg   <= csr_writedata[1];
                    2'd1:    length_reg <= csr_writedata[timeBits-1:0];
                    2'd2:    div_reg    <= csr_writedata[divBits-1:0];
                    default: ;
                endcase
            end else if (csr_read) begin
                case (csr_address)
                    2'd0:    csr_readdata_reg <= {28'd0, irq_reg, done_reg, loop_reg,
                                                  state_reg == PLAY};
                    2'd1:    csr_readdata_reg <= 32'(length_reg);
                    2'd2:    csr_readdata_reg <= 32'(div_reg);
                    default: csr_readdata_reg <= 32'(play_addr_reg);
                endcase
            end
            // RAM data lands one cycle after the tick; present it one cycle after that.
            tick_d_reg   <= tick;
            p_strobe_reg <= tick_d_reg;
            if (tick_d_reg)
                p_out_reg <= sample_q;
        end
    end

    assign csr_readdata = csr_readdata_reg;
    assign irq          = irq_reg;
    assign p_out        = p_out_reg;
    assign p_strobe     = p_strobe_reg;
    assign p_active     = (state_reg == PLAY);

endmodule

// File: tb/tb_pattern_player.sv
// Directed bench for pattern_player: a default-width instance plus a 48-bit / 2-lane instance
// sharing the same host bus, checked against hand-computed values.
module tb_pattern_player;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        buffer_write;
    logic [10:0] buf_addr;
    logic [31:0] buf_wdata;
    logic        csr_write;
    logic        csr_read;
    logic [1:0]  csr_address;
    logic [31:0] csr_wdata;

    logic [31:0] rdata_n, rdata_w;
    logic        irq_n, irq_w;
    logic [31:0] p_out_n;
    logic [47:0] p_out_w;
    logic        strobe_n, strobe_w;
    logic        active_n, active_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pattern_player dut (
        .clk(clk), .reset_n(reset_n),
        .buffer_write(buffer_write), .buffer_address(buf_addr[9:0]),
        .buffer_writedata(buf_wdata),
        .csr_write(csr_write), .csr_read(csr_read), .csr_address(csr_address),
        .csr_writedata(csr_wdata), .csr_readdata(rdata_n),
        .irq(irq_n), .p_out(p_out_n), .p_strobe(strobe_n), .p_active(active_n)
    );

    pattern_player #(.outputBits(48), .words_log_2(1)) dut_w (
        .clk(clk), .reset_n(reset_n),
        .buffer_write(buffer_write), .buffer_address(buf_addr),
        .buffer_writedata(buf_wdata),
        .csr_write(csr_write), .csr_read(csr_read), .csr_address(csr_address),
        .csr_writedata(csr_wdata), .csr_readdata(rdata_w),
        .irq(irq_w), .p_out(p_out_w), .p_strobe(strobe_w), .p_active(active_w)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hA0A0_0000 + 32'(i);
    endfunction

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_write = 1'b1; csr_address = a; csr_wdata = d;
        @(negedge clk);
        csr_write = 1'b0;
        $display("csr write addr=%0d data=0x%0h", a, d);
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        csr_read = 1'b1; csr_address = a;
        @(negedge clk);
        csr_read = 1'b0;
        d = rdata_n;
        $display("csr read  addr=%0d data=0x%0h", a, d);
    endtask

    task automatic buf_wr(input logic [10:0] a, input logic [31:0] d);
        @(negedge clk);
        buffer_write = 1'b1; buf_addr = a; buf_wdata = d;
        @(negedge clk);
        buffer_write = 1'b0;
        $display("buf write addr=%0d data=0x%0h", a, d);
    endtask

    initial begin
        logic [31:0] d;
        logic [8:0]  sbits;
        int          scount;

        reset_n = 1'b0; buffer_write = 1'b0; buf_addr = '0; buf_wdata = '0;
        csr_write = 1'b0; csr_read = 1'b0; csr_address = '0; csr_wdata = '0;

        // T1 reset state
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("t1_p_out", 64'(p_out_n), 64'h0);
        check_eq("t1_flags", 64'({strobe_n, irq_n, active_n}), 64'h0);
        csr_rd(2'd0, d); check_eq("t1_control", 64'(d), 64'h0);
        csr_rd(2'd1, d); check_eq("t1_length", 64'(d), 64'h3FF);
        csr_rd(2'd2, d); check_eq("t1_div", 64'(d), 64'h0);

        // T2 one-shot, DIV=0, LENGTH=3
        for (int i = 0; i < 4; i++) buf_wr(11'(i), pat(i));
        csr_wr(2'd1, 32'd3);
        csr_wr(2'd0, 32'h1);
        sbits = '0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            sbits[k-1] = strobe_n;
            if (k >= 2 && k <= 5) check_eq($sformatf("t2_p_out_%0d", k - 2), 64'(p_out_n), 64'(pat(k - 2)));
        end
        check_eq("t2_strobes", 64'(sbits[6:0]), 64'b0011110);
        check_eq("t2_irq", 64'(irq_n), 64'h1);
        check_eq("t2_active", 64'(active_n), 64'h0);
        csr_rd(2'd0, d); check_eq("t2_control", 64'(d), 64'hC);
        check_eq("t2_hold", 64'(p_out_n), 64'(pat(3)));

        // T3 rate divider DIV=2, LENGTH=1
        csr_wr(2'd0, 32'h8);
        check_eq("t3_irq_clr0", 64'(irq_n), 64'h0);
        csr_wr(2'd2, 32'd2);
        csr_wr(2'd1, 32'd1);
        csr_wr(2'd0, 32'h1);
        sbits = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            sbits[k-1] = strobe_n;
            if (k == 2) check_eq("t3_p_out_0", 64'(p_out_n), 64'(pat(0)));
            if (k == 3) check_eq("t3_irq_early", 64'(irq_n), 64'h0);
            if (k == 5) check_eq("t3_p_out_1", 64'(p_out_n), 64'(pat(1)));
        end
        check_eq("t3_strobes", 64'(sbits[5:0]), 64'b010010);
        check_eq("t3_irq", 64'(irq_n), 64'h1);
        csr_wr(2'd0, 32'h8);
        check_eq("t3_irq_clr", 64'(irq_n), 64'h0);

        // T4 looping playback then abort
        csr_wr(2'd2, 32'd0);
        csr_wr(2'd1, 32'd1);
        csr_wr(2'd0, 32'h3);
        sbits = '0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            sbits[k-1] = strobe_n;
            if (k >= 2) check_eq($sformatf("t4_p_out_%0d", k), 64'(p_out_n), 64'(pat((k - 2) % 2)));
        end
        check_eq("t4_strobes", 64'(sbits), 64'b111111110);
        check_eq("t4_irq_loop", 64'(irq_n), 64'h0);
        check_eq("t4_active", 64'(active_n), 64'h1);
        csr_wr(2'd0, 32'h2);
        scount = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (strobe_n) scount++;
        end
        check_eq("t4_stop_strobes", 64'(scount), 64'h0);
        check_eq("t4_inactive", 64'(active_n), 64'h0);
        check_eq("t4_irq", 64'(irq_n), 64'h0);
        csr_rd(2'd0, d); check_eq("t4_control", 64'(d), 64'h2);

        // T5 wide sample on the 48-bit instance
        buf_wr(11'd0, 32'h1122_3344);
        buf_wr(11'd1, 32'h0000_5566);
        csr_wr(2'd1, 32'd0);
        csr_wr(2'd0, 32'h1);
        repeat (2) @(negedge clk);
        check_eq("t5_strobe_w", 64'(strobe_w), 64'h1);
        check_eq("t5_p_out_w", 64'(p_out_w), 64'h5566_1122_3344);
        check_eq("t5_p_out_n", 64'(p_out_n), 64'h1122_3344);
        @(negedge clk);
        check_eq("t5_irq_w", 64'(irq_w), 64'h1);

        // T6 asynchronous reset in the middle of a looping run
        csr_wr(2'd1, 32'd1);
        csr_wr(2'd0, 32'h3);
        repeat (3) @(negedge clk);
        check_eq("t6_pre_flags", 64'({active_n, strobe_n, irq_n}), 64'b111);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t6_flags_n", 64'({active_n, strobe_n, irq_n}), 64'h0);
        check_eq("t6_flags_w", 64'({active_w, strobe_w, irq_w}), 64'h0);
        check_eq("t6_p_out", 64'(p_out_n), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        csr_rd(2'd0, d); check_eq("t6_control", 64'(d), 64'h0);
        csr_rd(2'd1, d); check_eq("t6_length", 64'(d), 64'h3FF);
        csr_wr(2'd1, 32'd0);
        csr_wr(2'd0, 32'h1);
        repeat (2) @(negedge clk);
        check_eq("t6_mem_n", 64'(p_out_n), 64'h1122_3344);
        check_eq("t6_mem_w", 64'(p_out_w), 64'h5566_1122_3344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
